// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared image geometry, timeout and feeder state encoding
package cnn_pkg;

  localparam int IMG_PIXELS     = 784;
  localparam int DATA_BITS      = 8;
  localparam int TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    S_LOAD,
    S_KICK,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/pixel_buffer.sv
// rtl/pixel_buffer.sv - single-clock image RAM, one write port, one registered read port
module pixel_buffer #(
  parameter int DEPTH     = 784,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [DATA_BITS-1:0] o_rd_data
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register doubles as the pixel output: it drops to zero whenever no read is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_data <= '0;
    end else if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end else begin
      o_rd_data <= '0;
    end
  end

endmodule

// File: rtl/image_feeder.sv
// rtl/image_feeder.sv - buffers one image from the host, streams it to the CNN, captures the class (optional WAIT timeout: IMAGE_FEEDER_TIMEOUT_EN)
module image_feeder #(
  parameter int IMG_PIXELS = cnn_pkg::IMG_PIXELS,
  parameter int DATA_BITS  = cnn_pkg::DATA_BITS,
  parameter int ADDR_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_valid,
  input  logic [DATA_BITS-1:0] host_data,
  output logic                 host_ready,
  output logic                 cnn_rst_n,
  output logic [DATA_BITS-1:0] px_out,
  input  logic [3:0]           dec_in,
  input  logic                 dec_valid,
  output logic [3:0]           result,
  output logic                 result_valid,
  output logic                 busy
);
  import cnn_pkg::*;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_BITS-1:0] r_wr_idx;
  logic [ADDR_BITS:0]   r_rd_idx;
  logic                 r_dec_got;
  logic [3:0]           r_dec_val;
  logic                 r_cnn_rst_n;
  logic [3:0]           r_result;
  logic                 r_result_valid;
  logic                 w_wr_en;
  logic                 w_wr_last;
  logic                 w_rd_en;
  logic                 w_rd_end;
  logic                 w_dec_now;
  logic                 w_timeout;

  assign w_wr_en   = host_valid && (r_state == S_LOAD);
  assign w_wr_last = (r_wr_idx == ADDR_BITS'(IMG_PIXELS - 1));
  // rd_idx reaches IMG_PIXELS in the cycle the last pixel is on px_out
  assign w_rd_end  = (r_rd_idx == (ADDR_BITS + 1)'(IMG_PIXELS));
  // only the first decision of an image counts, and only while the chain runs
  assign w_dec_now = dec_valid && !r_dec_got && ((r_state == S_STREAM) || (r_state == S_WAIT));

`ifdef IMAGE_FEEDER_TIMEOUT_EN
  logic [15:0] r_wait_cnt;

  // Counts cycles spent in WAIT; restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_WAIT)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and buffer read control.
  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_wr_en && w_wr_last) begin
          w_next = S_KICK;
        end
      end
      S_KICK: begin
        w_rd_en = 1'b1;
        w_next  = S_STREAM;
      end
      S_STREAM: begin
        w_rd_en = !w_rd_end;
        if (w_rd_end) begin
          w_next = (r_dec_got || w_dec_now) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_dec_now || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_LOAD;
      end
      default: begin
        w_next = S_LOAD;
      end
    endcase
  end

  // Indices, decision latch, CNN reset and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_idx       <= '0;
      r_rd_idx       <= '0;
      r_dec_got      <= 1'b0;
      r_dec_val      <= '0;
      r_cnn_rst_n    <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_idx <= w_wr_last ? '0 : r_wr_idx + 1'b1;
      end
      r_rd_idx <= w_rd_en ? r_rd_idx + 1'b1 : '0;
      if (r_state == S_KICK) begin
        r_dec_got <= 1'b0;
      end else if (w_dec_now) begin
        r_dec_got <= 1'b1;
        r_dec_val <= dec_in;
      end
      if (w_next == S_KICK) begin
        r_cnn_rst_n <= 1'b0;
      end else if (w_next == S_STREAM) begin
        r_cnn_rst_n <= 1'b1;
      end
      r_result_valid <= (w_next == S_DONE);
      if (w_next == S_DONE) begin
        r_result <= w_dec_now ? dec_in : (r_dec_got ? r_dec_val : 4'hF);
      end
    end
  end

  pixel_buffer #(
    .DEPTH     (IMG_PIXELS),
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_buf (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_idx),
    .i_wr_data (host_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_idx[ADDR_BITS-1:0]),
    .o_rd_data (px_out)
  );

  assign host_ready   = (r_state == S_LOAD);
  assign busy         = (r_state == S_STREAM) || (r_state == S_WAIT);
  assign cnn_rst_n    = r_cnn_rst_n;
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule
